// File: rtl/char_line_ptr_ctrl.sv
// Char/line pointer controller for a multi-line packet RAM: write/read char
// pointers, per-line last-char table, line FIFO state, overflow drop and
// occupancy accounting.
module char_line_ptr_ctrl #(
   parameter int unsigned CHAR_W = 11,
   parameter int unsigned LINE_W = 2,
   parameter int unsigned DROP_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_char_incr,
   input  logic                     wr_commit,
   input  logic                     wr_abort,
   input  logic                     rd_char_incr,
   input  logic                     rd_release,
   output logic                     wr_greenflag,
   output logic                     rd_greenflag,
   output logic                     tlast_flag,
   output logic                     wr_ovf,
   output logic [LINE_W+CHAR_W-1:0] rd_ptr,
   output logic [LINE_W+CHAR_W-1:0] wr_ptr,
   output logic [LINE_W:0]          used_lines,
   output logic [DROP_W-1:0]        drop_cnt
);

   localparam int unsigned LCNT_W = LINE_W + 1;
   localparam int unsigned NLINES = 1 << LINE_W;

   logic [CHAR_W-1:0] wr_char_q, wr_char_d;
   logic [CHAR_W-1:0] rd_char_q, rd_char_d;
   logic [LCNT_W-1:0] wr_line_q, wr_line_d;
   logic [LCNT_W-1:0] rd_line_q, rd_line_d;
   logic              wr_ovf_q, wr_ovf_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [CHAR_W-1:0] tlast_q [NLINES];
   logic              tlast_we;
   logic              full_c;
   logic              empty_c;

   // Line FIFO status: extra line MSB distinguishes full from empty.
   assign full_c  = (wr_line_q[LINE_W] != rd_line_q[LINE_W]) &&
                    (wr_line_q[LINE_W-1:0] == rd_line_q[LINE_W-1:0]);
   assign empty_c = (wr_line_q == rd_line_q);

   assign wr_greenflag = !full_c;
   assign rd_greenflag = !empty_c;
   assign tlast_flag   = !empty_c && (rd_char_q == tlast_q[rd_line_q[LINE_W-1:0]]);
   assign wr_ptr       = {wr_line_q[LINE_W-1:0], wr_char_q};
   assign rd_ptr       = {rd_line_q[LINE_W-1:0], rd_char_q};
   assign used_lines   = wr_line_q - rd_line_q;
   assign wr_ovf       = wr_ovf_q;
   assign drop_cnt     = drop_q;

   // Write side next state: abort beats commit, commit beats char increment.
   always_comb begin
      wr_char_d = wr_char_q;
      wr_line_d = wr_line_q;
      wr_ovf_d  = wr_ovf_q;
      drop_d    = drop_q;
      tlast_we  = 1'b0;
      if (!full_c) begin
         if (wr_abort) begin
            wr_char_d = '0;
            wr_ovf_d  = 1'b0;
         end else if (wr_commit) begin
            wr_char_d = '0;
            wr_ovf_d  = 1'b0;
            if (wr_ovf_q) begin
               if (drop_q != {DROP_W{1'b1}}) drop_d = drop_q + DROP_W'(1);
            end else begin
               tlast_we  = 1'b1;
               wr_line_d = wr_line_q + LCNT_W'(1);
            end
         end else if (wr_char_incr) begin
            if (wr_char_q == {CHAR_W{1'b1}}) wr_ovf_d = 1'b1;
            else                             wr_char_d = wr_char_q + CHAR_W'(1);
         end
      end
   end

   // Read side next state: release beats increment; increment holds on last char.
   always_comb begin
      rd_char_d = rd_char_q;
      rd_line_d = rd_line_q;
      if (!empty_c) begin
         if (rd_release) begin
            rd_char_d = '0;
            rd_line_d = rd_line_q + LCNT_W'(1);
         end else if (rd_char_incr && !tlast_flag) begin
            rd_char_d = rd_char_q + CHAR_W'(1);
         end
      end
   end

   // Pointer and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_char_q <= '0;
         rd_char_q <= '0;
         wr_line_q <= '0;
         rd_line_q <= '0;
         wr_ovf_q  <= 1'b0;
         drop_q    <= '0;
      end else begin
         wr_char_q <= wr_char_d;
         rd_char_q <= rd_char_d;
         wr_line_q <= wr_line_d;
         rd_line_q <= rd_line_d;
         wr_ovf_q  <= wr_ovf_d;
         drop_q    <= drop_d;
      end
   end

   // Per-line last-char table, written on a valid commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NLINES; i++) tlast_q[i] <= '0;
      end else if (tlast_we) begin
         tlast_q[wr_line_q[LINE_W-1:0]] <= wr_char_q;
      end
   end

endmodule

// File: tb/tb_char_line_ptr_ctrl.sv
// Scoreboard bench for char_line_ptr_ctrl: a frame-level queue model predicts
// the post-edge outputs, a monitor compares them one cycle later.
module tb_char_line_ptr_ctrl;

   localparam int unsigned CHAR_W = 11;
   localparam int unsigned LINE_W = 2;
   localparam int unsigned DROP_W = 16;
   localparam int unsigned PTR_W  = LINE_W + CHAR_W;
   localparam int          NL     = 1 << LINE_W;
   localparam int          CHARS  = 1 << CHAR_W;
   localparam int          DMAX   = (1 << DROP_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wr_char_incr = 1'b0, wr_commit = 1'b0, wr_abort = 1'b0;
   logic rd_char_incr = 1'b0, rd_release = 1'b0;
   logic wr_greenflag, rd_greenflag, tlast_flag, wr_ovf;
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [LINE_W:0]   used_lines;
   logic [DROP_W-1:0] drop_cnt;

   char_line_ptr_ctrl #(.CHAR_W(CHAR_W), .LINE_W(LINE_W), .DROP_W(DROP_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_char_incr(wr_char_incr), .wr_commit(wr_commit), .wr_abort(wr_abort),
      .rd_char_incr(rd_char_incr), .rd_release(rd_release),
      .wr_greenflag(wr_greenflag), .rd_greenflag(rd_greenflag),
      .tlast_flag(tlast_flag), .wr_ovf(wr_ovf),
      .rd_ptr(rd_ptr), .wr_ptr(wr_ptr),
      .used_lines(used_lines), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              wg, rg, tf, ovf;
      logic [PTR_W-1:0]  rp, wp;
      logic [LINE_W:0]   used;
      logic [DROP_W-1:0] drop;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Frame-level reference: committed frames are a queue of last-char indices.
   int cq[$];
   int wchar = 0, rchar = 0, wl = 0, rl = 0, drop = 0;
   bit ovf = 1'b0;

   function automatic exp_t model_out();
      exp_t e;
      e.wg   = (cq.size() < NL);
      e.rg   = (cq.size() > 0);
      e.tf   = (cq.size() > 0) && (rchar == cq[0]);
      e.ovf  = ovf;
      e.rp   = PTR_W'((rl % NL) * CHARS + rchar);
      e.wp   = PTR_W'((wl % NL) * CHARS + wchar);
      e.used = (LINE_W+1)'(cq.size());
      e.drop = DROP_W'(drop);
      return e;
   endfunction

   task automatic model_step(bit r, bit wi, bit wc, bit wa, bit ri, bit rr);
      bit wg, rg, tf;
      if (!r) begin
         cq.delete();
         wchar = 0; rchar = 0; wl = 0; rl = 0; drop = 0; ovf = 1'b0;
         return;
      end
      wg = (cq.size() < NL);
      rg = (cq.size() > 0);
      tf = rg && (rchar == cq[0]);
      if (rg) begin
         if (rr) begin
            void'(cq.pop_front());
            rl++;
            rchar = 0;
         end else if (ri && !tf) begin
            rchar++;
         end
      end
      if (wg) begin
         if (wa) begin
            wchar = 0; ovf = 1'b0;
         end else if (wc) begin
            if (ovf) begin
               if (drop < DMAX) drop++;
            end else begin
               cq.push_back(wchar);
               wl++;
            end
            wchar = 0; ovf = 1'b0;
         end else if (wi) begin
            if (wchar == CHARS - 1) ovf = 1'b1;
            else                    wchar++;
         end
      end
   endtask

   // One cycle of stimulus: predict, queue expectation, drive inputs.
   task automatic drive(bit r, bit wi, bit wc, bit wa, bit ri, bit rr);
      @(negedge clk);
      model_step(r, wi, wc, wa, ri, rr);
      exp_q.push_back(model_out());
      rst_n = r; wr_char_incr = wi; wr_commit = wc; wr_abort = wa;
      rd_char_incr = ri; rd_release = rr;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every cycle after the edge, compare outputs with the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_greenflag", 64'(wr_greenflag), 64'(e.wg));
            chk("rd_greenflag", 64'(rd_greenflag), 64'(e.rg));
            chk("tlast_flag",   64'(tlast_flag),   64'(e.tf));
            chk("wr_ovf",       64'(wr_ovf),       64'(e.ovf));
            chk("rd_ptr",       64'(rd_ptr),       64'(e.rp));
            chk("wr_ptr",       64'(wr_ptr),       64'(e.wp));
            chk("used_lines",   64'(used_lines),   64'(e.used));
            chk("drop_cnt",     64'(drop_cnt),     64'(e.drop));
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      // Single frame, read to last char and beyond, release.
      repeat (5) drive(1, 1, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      repeat (7) drive(1, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 1, 1);
      drive(1, 0, 0, 0, 0, 0);
      // Fill all lines, extra commit while full, then one release.
      for (int i = 0; i < NL; i++) begin
         repeat (i + 1) drive(1, 1, 0, 0, 0, 0);
         drive(1, 0, 1, 0, 0, 0);
      end
      drive(1, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0);
      // Overflow and dropped commit.
      repeat (CHARS) drive(1, 1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      // Abort beats commit.
      repeat (3) drive(1, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 0, 0);
      // Bring occupancy to two, then commit and release together.
      drive(1, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 1, 1);
      drive(1, 0, 0, 0, 0, 0);
      // Mid-frame reset.
      repeat (10) drive(1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         drive($urandom_range(199) != 0,
               $urandom_range(99) < 60, $urandom_range(99) < 12,
               $urandom_range(99) < 3,  $urandom_range(99) < 55,
               $urandom_range(99) < 10);
      end
      drive(1, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
